// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU push side and uart_tx handshake side of the transmit FIFO.
// Rev 1.0
`default_nettype none

interface uart_tx_fifo_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
);
   localparam int PTR_W = $clog2(DEPTH);

   logic              wr_start_i;
   logic [DATA_W-1:0] wr_data_i;
   logic              busy_o;
   logic              flush_i;
   logic              tx_start_o;
   logic [DATA_W-1:0] tx_data_o;
   logic              tx_busy_i;
   logic [PTR_W:0]    level_o;
   logic              overflow_o;

   modport slave (
      input  wr_start_i, wr_data_i, flush_i, tx_busy_i,
      output busy_o, tx_start_o, tx_data_o, level_o, overflow_o
   );

   modport master (
      output wr_start_i, wr_data_i, flush_i, tx_busy_i,
      input  busy_o, tx_start_o, tx_data_o, level_o, overflow_o
   );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte buffer drained into uart_tx by a start/busy handshake FSM.
// Rev 1.0
`default_nettype none

module uart_tx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  wire logic      clk_i,
   input  wire logic      rst_i,
   uart_tx_fifo_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);
   localparam logic [1:0]     C_ACK_LAST = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LAUNCH    = 2'd1,
      S_WAIT_ACK  = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic              r_overflow;
   logic [DATA_W-1:0] r_tx_data;
   logic [1:0]        r_ack_cnt;
   state_t            r_state;

   state_t            w_state_nxt;
   logic [1:0]        w_ack_cnt_nxt;
   logic              w_tx_start;
   logic              w_full;
   logic              w_push;
   logic              w_drop;
   logic              w_pop;
   logic              w_load;

   assign w_full = (r_count == C_DEPTH);
   assign w_push = bus.wr_start_i & ~bus.flush_i & ~w_full;
   assign w_drop = bus.wr_start_i & ~bus.flush_i &  w_full;
   // Pop is suppressed by flush because flush already empties the buffer.
   assign w_pop  = (r_state == S_LAUNCH) & ~bus.flush_i;
   assign w_load = (r_state == S_IDLE) & (w_state_nxt == S_LAUNCH);

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.wr_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (bus.flush_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_ack_cnt <= 2'd0;
         r_tx_data <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ack_cnt <= w_ack_cnt_nxt;
         if (w_load) begin
            r_tx_data <= r_mem[r_rd_ptr];
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ack_cnt_nxt = r_ack_cnt;
      w_tx_start    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((r_count != '0) && !bus.tx_busy_i && !bus.flush_i) begin
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_tx_start    = 1'b1;
            w_ack_cnt_nxt = 2'd0;
            w_state_nxt   = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            // A uart_tx that never reports busy must not stall the queue forever.
            if (bus.tx_busy_i) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (r_ack_cnt == C_ACK_LAST) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_ack_cnt_nxt = r_ack_cnt + 2'd1;
            end
         end
         S_WAIT_DONE: begin
            if (!bus.tx_busy_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.busy_o     = w_full;
   assign bus.tx_start_o = w_tx_start;
   assign bus.tx_data_o  = r_tx_data;
   assign bus.level_o    = r_count;
   assign bus.overflow_o = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random checks of uart_tx_fifo against a queue model.
// Rev 1.0
`default_nettype none

module tb_uart_tx_fifo;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;

   logic clk;
   logic rst;

   uart_tx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] q[$];
   logic [7:0] emitted[$];
   int         start_cyc[$];
   logic       ovf_m     = 1'b0;
   int         busy_cnt  = 0;
   logic       hold_busy = 1'b0;
   logic       ignore_st = 1'b0;
   int         uart_len  = 2;
   logic       prev_busy = 1'b0;
   int         cyc       = 0;
   int         n_starts  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check registered outputs against the model, advance the model.
   task automatic step(input logic wr, input logic [7:0] d, input logic fl);
      logic busy_now;
      logic started;
      busy_now       = hold_busy || (busy_cnt > 0);
      bus.wr_start_i = wr;
      bus.wr_data_i  = d;
      bus.flush_i    = fl;
      bus.tx_busy_i  = busy_now;
      chk("level", 32'(bus.level_o), 32'(q.size()));
      chk("busy_o", 32'(bus.busy_o), 32'(q.size() == DEPTH));
      chk("overflow", 32'(bus.overflow_o), 32'(ovf_m));
      started = (bus.tx_start_o === 1'b1);
      if (started) begin
         chk("start_nonempty", 32'(q.size() != 0), 32'd1);
         chk("start_uart_idle_before", 32'(prev_busy), 32'd0);
         chk("start_no_overlap", 32'(busy_cnt), 32'd0);
         if (q.size() != 0) begin
            chk("tx_data", 32'(bus.tx_data_o), 32'(q[0]));
         end
         emitted.push_back(bus.tx_data_o);
         start_cyc.push_back(cyc);
         n_starts++;
      end
      if (fl) begin
         q.delete();
         ovf_m = 1'b0;
      end else begin
         if (wr) begin
            if (q.size() == DEPTH) ovf_m = 1'b1;
            else q.push_back(d);
         end
         if (started && q.size() != 0) void'(q.pop_front());
      end
      if (busy_cnt > 0) busy_cnt--;
      if (started && !ignore_st) busy_cnt = (uart_len == 0) ? int'($urandom_range(1, 5)) : uart_len;
      prev_busy = busy_now;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound && (q.size() != 0 || busy_cnt != 0); i++) step(1'b0, 8'h00, 1'b0);
      chk("drain_done", 32'(q.size()), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;
      int c0;
      rst            = 1'b1;
      bus.wr_start_i = 1'b0;
      bus.wr_data_i  = '0;
      bus.flush_i    = 1'b0;
      bus.tx_busy_i  = 1'b0;
      #2;
      chk("rst_tx_start", 32'(bus.tx_start_o), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data_o), 32'd0);
      chk("rst_level", 32'(bus.level_o), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_overflow", 32'(bus.overflow_o), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single byte latency
      emitted.delete();
      c0 = cyc;
      step(1'b1, 8'h41, 1'b0);
      chk("single_level_1", 32'(bus.level_o), 32'd1);
      for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0);
      chk("single_count", 32'(n_starts), 32'd1);
      chk("single_latency", 32'(start_cyc[0] - c0), 32'd2);
      chk("single_data", 32'(emitted[0]), 32'h41);
      chk("single_level_0", 32'(bus.level_o), 32'd0);
      drain(50);

      // Full and overflow
      hold_busy = 1'b1;
      emitted.delete();
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("full_level", 32'(bus.level_o), 32'd8);
      chk("full_busy", 32'(bus.busy_o), 32'd1);
      step(1'b1, 8'hFF, 1'b0);
      chk("ovf_set", 32'(bus.overflow_o), 32'd1);
      chk("ovf_level", 32'(bus.level_o), 32'd8);
      hold_busy = 1'b0;
      uart_len  = 2;
      drain(300);
      chk("full_emitted_n", 32'(emitted.size()), 32'd8);
      for (int i = 0; i < 8 && i < emitted.size(); i++) chk("full_order", 32'(emitted[i]), 32'(i + 1));

      // Push coincident with pop
      hold_busy = 1'b1;
      emitted.delete();
      step(1'b1, 8'hA1, 1'b0);
      step(1'b1, 8'hA2, 1'b0);
      step(1'b1, 8'hA3, 1'b0);
      hold_busy = 1'b0;
      for (int i = 0; i < 20 && bus.tx_start_o !== 1'b1; i++) step(1'b0, 8'h00, 1'b0);
      chk("simul_launch_seen", 32'(bus.tx_start_o), 32'd1);
      chk("simul_level_pre", 32'(bus.level_o), 32'd3);
      step(1'b1, 8'hA4, 1'b0);
      chk("simul_level_post", 32'(bus.level_o), 32'd3);
      drain(200);
      chk("simul_emitted_n", 32'(emitted.size()), 32'd4);
      for (int i = 0; i < 4 && i < emitted.size(); i++) chk("simul_order", 32'(emitted[i]), 32'(8'hA1 + i));

      // Acknowledge timeout
      ignore_st = 1'b1;
      start_cyc.delete();
      step(1'b1, 8'hE1, 1'b0);
      step(1'b1, 8'hE2, 1'b0);
      for (int i = 0; i < 30 && start_cyc.size() < 2; i++) step(1'b0, 8'h00, 1'b0);
      chk("timeout_starts", 32'(start_cyc.size()), 32'd2);
      if (start_cyc.size() >= 2) chk("timeout_gap", 32'(start_cyc[1] - start_cyc[0]), 32'd6);
      ignore_st = 1'b0;
      drain(100);

      // Flush while in WAIT_DONE (overflow still set from earlier)
      uart_len = 20;
      for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("flush_pre_level", 32'(bus.level_o), 32'd5);
      chk("flush_pre_ovf", 32'(bus.overflow_o), 32'd1);
      step(1'b0, 8'h00, 1'b1);
      chk("flush_level", 32'(bus.level_o), 32'd0);
      chk("flush_ovf", 32'(bus.overflow_o), 32'd0);
      n0 = n_starts;
      for (int i = 0; i < 30; i++) step(1'b0, 8'h00, 1'b0);
      chk("flush_no_start", 32'(n_starts), 32'(n0));
      drain(50);

      // Asynchronous reset during WAIT_DONE
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("areset_pre_level", 32'(bus.level_o), 32'd4);
      #3;
      rst = 1'b1;
      #1;
      chk("areset_tx_start", 32'(bus.tx_start_o), 32'd0);
      chk("areset_tx_data", 32'(bus.tx_data_o), 32'd0);
      chk("areset_level", 32'(bus.level_o), 32'd0);
      chk("areset_busy", 32'(bus.busy_o), 32'd0);
      chk("areset_overflow", 32'(bus.overflow_o), 32'd0);
      q.delete();
      ovf_m = 1'b0;
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      n0 = n_starts;
      for (int i = 0; i < 30; i++) step(1'b0, 8'h00, 1'b0);
      chk("areset_no_start", 32'(n_starts), 32'(n0));
      drain(50);

      // Random traffic
      uart_len = 0;
      for (int i = 0; i < 600; i++) begin
         if (i % 25 == 0) hold_busy = ($urandom_range(0, 3) == 0);
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 49) == 0));
      end
      hold_busy = 1'b0;
      drain(500);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
